// File: rtl/seg_walker_multi.sv
// Multi-digit seven-segment walker: a cursor segment steps across DIGITS digits,
// optionally leaving a flashing-cursor trail, shown on a time-multiplexed display.
module seg_walker_multi #(
   parameter int DIGITS       = 4,
   parameter int INIT_CYCLES  = 300000000,
   parameter int FALL_CYCLES  = 150000000,
   parameter int FLASH_CYCLES = 33554432,
   parameter int SCAN_CYCLES  = 131072
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              right,
   input  logic              left,
   input  logic              up,
   input  logic              down,
   output logic [DIGITS-1:0] DIGIT,
   output logic [6:0]        DISPLAY,
   output logic [1:0]        pos,
   output logic [2:0]        cur_digit,
   output logic [1:0]        state_out,
   output logic              invalid_move
);

   localparam int IW = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;
   localparam int FW = (FALL_CYCLES  > 1) ? $clog2(FALL_CYCLES)  : 1;
   localparam int LW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam int SW = (SCAN_CYCLES  > 1) ? $clog2(SCAN_CYCLES)  : 1;

   localparam logic [2:0] SA = 3'd0, SB = 3'd1, SC = 3'd2, SD = 3'd3,
                          SE = 3'd4, SF = 3'd5, SG = 3'd6;
   localparam logic [1:0] HR = 2'd0, HL = 2'd1, HU = 2'd2, HD = 2'd3;
   localparam logic [2:0] LAST_DIG = 3'(DIGITS - 1);

   typedef enum logic [1:0] {S_INIT = 2'b00, S_MOVE = 2'b01, S_FALL = 2'b10} state_t;

   state_t                 state;
   logic [2:0]             seg, cur_dig, scan_idx;
   logic [1:0]             hd;
   logic [DIGITS-1:0][6:0] trail, cur_mask, nx_mask, dig_lit;
   logic [IW-1:0]          init_cnt;
   logic [FW-1:0]          fall_cnt;
   logic [LW-1:0]          flash_cnt;
   logic [SW-1:0]          scan_cnt;
   logic                   flash_on;
   logic [4:0]             key, tr_res, tl_res, st_res, nx_res;
   logic                   tr_ok, tl_ok, st_ok, nx_ok;
   logic [2:0]             st_dig, nx_dig;
   logic [6:0]             seg_oh, nx_oh, scan_lit;
   logic                   mv_btn, enter_fall;

   assign key        = {seg, hd};
   assign mv_btn     = right | left | up;
   assign enter_fall = (state == S_MOVE) && !mv_btn && down;
   assign seg_oh     = 7'd1 << seg;
   assign nx_oh      = 7'd1 << nx_res[4:2];

   always_comb begin
      tr_ok = 1'b1; tr_res = key;
      case (key)
         {SA, HR}: tr_res = {SB, HD};
         {SB, HD}: tr_res = {SG, HL};
         {SC, HD}: tr_res = {SD, HL};
         {SD, HL}: tr_res = {SE, HU};
         {SE, HU}: tr_res = {SG, HR};
         {SF, HU}: tr_res = {SA, HR};
         {SG, HR}: tr_res = {SC, HD};
         {SG, HL}: tr_res = {SF, HU};
         default:  tr_ok  = 1'b0;
      endcase
      tl_ok = 1'b1; tl_res = key;
      case (key)
         {SA, HL}: tl_res = {SF, HD};
         {SB, HU}: tl_res = {SA, HL};
         {SC, HU}: tl_res = {SG, HL};
         {SD, HR}: tl_res = {SC, HU};
         {SE, HD}: tl_res = {SD, HR};
         {SF, HD}: tl_res = {SG, HR};
         {SG, HL}: tl_res = {SE, HD};
         {SG, HR}: tl_res = {SB, HU};
         default:  tl_ok  = 1'b0;
      endcase
      // horizontal segments keep segment/heading and step to the neighbouring digit
      st_ok = 1'b1; st_res = key; st_dig = cur_dig;
      case (key)
         {SB, HD}: st_res = {SC, HD};
         {SC, HU}: st_res = {SB, HU};
         {SE, HU}: st_res = {SF, HU};
         {SF, HD}: st_res = {SE, HD};
         {SA, HR}, {SG, HR}, {SD, HR}: begin
            st_ok  = (cur_dig != 3'd0);
            st_dig = cur_dig - 3'd1;
         end
         {SA, HL}, {SG, HL}, {SD, HL}: begin
            st_ok  = (cur_dig < LAST_DIG);
            st_dig = cur_dig + 3'd1;
         end
         default: st_ok = 1'b0;
      endcase
      {nx_res, nx_dig, nx_ok} = {st_res, st_dig, st_ok};
      if (right)     {nx_res, nx_dig, nx_ok} = {tr_res, cur_dig, tr_ok};
      else if (left) {nx_res, nx_dig, nx_ok} = {tl_res, cur_dig, tl_ok};
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign cur_mask[i] = (cur_dig == 3'(i)) ? seg_oh : 7'd0;
      assign nx_mask[i]  = (nx_dig  == 3'(i)) ? nx_oh  : 7'd0;
      assign dig_lit[i]  = (state == S_FALL)
                         ? ((trail[i] & ~cur_mask[i]) | (flash_on ? cur_mask[i] : 7'd0))
                         : cur_mask[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT; seg <= SG; hd <= HL; cur_dig <= 3'd0;
         trail <= '0; init_cnt <= '0; fall_cnt <= '0; invalid_move <= 1'b0;
      end else begin
         invalid_move <= 1'b0;
         case (state)
            S_INIT: begin
               seg <= SG; hd <= HL; cur_dig <= 3'd0; trail <= '0; fall_cnt <= '0;
               if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                  state    <= S_MOVE;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: begin
               if (mv_btn) begin
                  if (nx_ok) begin
                     seg <= nx_res[4:2]; hd <= nx_res[1:0]; cur_dig <= nx_dig;
                     if (state == S_FALL) trail <= trail | nx_mask;
                  end else begin
                     invalid_move <= 1'b1;
                  end
               end else if (down) begin
                  state <= S_FALL;
                  if (state == S_MOVE) trail <= cur_mask;
               end
               if ((mv_btn && nx_ok) || (!mv_btn && down) || state == S_MOVE)
                  fall_cnt <= '0;
               else if (fall_cnt == FW'(FALL_CYCLES - 1)) begin
                  state    <= S_INIT;
                  fall_cnt <= '0;
               end else
                  fall_cnt <= fall_cnt + 1'b1;
            end
         endcase
      end
   end

   // flash phase restarts lit on each entry; moves inside FALLING do not re-phase it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flash_cnt <= '0; flash_on <= 1'b1;
      end else if (enter_fall) begin
         flash_cnt <= '0; flash_on <= 1'b1;
      end else if (state == S_FALL) begin
         if (flash_cnt == LW'(FLASH_CYCLES - 1)) begin
            flash_cnt <= '0;
            flash_on  <= ~flash_on;
         end else begin
            flash_cnt <= flash_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      scan_lit = 7'd0;
      for (int i = 0; i < DIGITS; i++)
         if (scan_idx == 3'(i)) scan_lit = dig_lit[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0; scan_idx <= 3'd0;
         DIGIT    <= {{(DIGITS-1){1'b1}}, 1'b0};
         DISPLAY  <= 7'b0111111;
      end else begin
         if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == LAST_DIG) ? 3'd0 : scan_idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         DIGIT   <= ~(DIGITS'(1) << scan_idx);
         DISPLAY <= ~scan_lit;
      end
   end

   assign pos       = hd;
   assign cur_digit = cur_dig;
   assign state_out = state;

endmodule

// File: doc/seg_walker_multi.md
Name: seg_walker_multi

Overview:
- Multi-digit successor of the single-digit seven-segment walker game.
- A cursor segment walks across DIGITS seven-segment digits using turn and straight moves; horizontal segments can cross into neighbouring digits.
- A marking mode (FALLING) leaves a persistent trail and flashes the cursor.
- Runs on the board clock with internal clock enables instead of divided clocks; the display is time-multiplexed. Button inputs arrive already debounced and one-pulsed in the clk domain.

Parameters:
- DIGITS, 4, number of digits (2..8); digit 0 is rightmost.
- INIT_CYCLES, 300000000, clk cycles spent in INITIAL before entering MOVING.
- FALL_CYCLES, 150000000, clk cycles of FALLING with no move before returning to INITIAL.
- FLASH_CYCLES, 33554432, clk cycles per cursor flash half-period.
- SCAN_CYCLES, 131072, clk cycles per digit during display scan.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- right  in  1  one-cycle pulse: turn right.
- left  in  1  one-cycle pulse: turn left.
- up  in  1  one-cycle pulse: go straight.
- down  in  1  one-cycle pulse: enter or extend FALLING.
- DIGIT  out  DIGITS  anode enables, active-low, one-hot-low.
- DISPLAY  out  7  segments, active-low; bit0=A … bit6=G.
- pos  out  2  heading: 0=RIGHT, 1=LEFT, 2=UP, 3=DOWN.
- cur_digit  out  3  digit index of the cursor.
- state_out  out  2  00=INITIAL, 01=MOVING, 10=FALLING.
- invalid_move  out  1  registered one-cycle pulse flagging a rejected move.

Behaviour:
- Reset:
  - state INITIAL; cursor at digit 0, segment G, heading LEFT; trail cleared; timers and scan counter 0.
  - invalid_move=0, DIGIT=~1 (digit 0 enabled), DISPLAY=7'b0111111.
- Timing: all register updates occur on posedge clk. Moves take effect on the edge that samples the pulse. invalid_move is high for exactly the following cycle.
- Button priority: right > left > up > down. Lower-priority pulses in the same cycle are dropped silently.
- INITIAL:
  - All buttons ignored; invalid_move is never raised.
  - The cursor is forced to digit 0 / G / LEFT and the trail is cleared.
  - After INIT_CYCLES cycles, go to MOVING.
- Turn-right table (seg,heading -> seg,heading):
  - A,R->B,D; B,D->G,L; C,D->D,L; D,L->E,U.
  - E,U->G,R; F,U->A,R; G,R->C,D; G,L->F,U.
- Turn-left table:
  - A,L->F,D; B,U->A,L; C,U->G,L; D,R->C,U.
  - E,D->D,R; F,D->G,R; G,L->E,D; G,R->B,U.
- Straight (up) within a digit: B,D->C,D; C,U->B,U; E,U->F,U; F,D->E,D.
- Straight across digits:
  - On A, G or D heading RIGHT: same segment and heading, digit-1. Legal only if digit>0.
  - Heading LEFT: digit+1. Legal only if digit<DIGITS-1.
- Any press not listed above: the cursor is unchanged and invalid_move is pulsed. This includes edge crossings.
- MOVING:
  - Display shows the cursor segment only, steady.
  - down -> FALLING; the trail is set to the cursor segment only.
- FALLING:
  - The fall timer is reset on entry, on every legal move, and on down.
  - Each legal move ORs the new cursor position into the trail (DIGITS×7 bits).
  - Display shows the trail steady; the cursor segment blinks, toggling every FLASH_CYCLES (lit in the first half-period after entry).
  - When the timer reaches FALL_CYCLES, go to INITIAL.
- Scan:
  - The active digit index advances every SCAN_CYCLES and wraps from DIGITS-1 to 0.
  - DIGIT drives one low bit; DISPLAY shows that digit's content, registered one cycle (DIGIT and DISPLAY change together).
- Widths: counters are sized with $clog2 of their parameter. All counters wrap or saturate without X.
- Reset asserted mid-operation: immediate return to the reset values listed above; pending pulses are lost.

Test Plan:
- Bench parameters: DIGITS=2, INIT_CYCLES=8, FALL_CYCLES=20, FLASH_CYCLES=2, SCAN_CYCLES=1.
- Reset and INITIAL: release rst, pulse right at cycle 3 -> invalid_move stays 0, state_out=00. At cycle 8, state_out=01 with digit0/G/LEFT.
- Turns: in MOVING, pulse right -> seg F, pos=2. Pulse right -> A, pos=0. Pulse up -> invalid_move 1-cycle pulse, since digit 0 heading RIGHT cannot cross.
- Crossing: from A heading LEFT at digit 0, pulse up -> cur_digit=1, seg A, pos=1. Pulse up again -> invalid_move.
- FALLING trail: from G/LEFT, pulse down then left then left -> trail = {G,E,D}. Non-cursor segments in digit 0 are steady low on DISPLAY; the cursor segment toggles every 2 cycles. No move for 20 cycles -> state_out=00 and trail cleared.
- Priority: right and up in the same cycle at G/LEFT -> moves to F/UP, no invalid_move.
- Scan and reset: DIGIT alternates 2'b10/2'b01 each cycle. Assert rst mid-FALLING -> DIGIT=2'b10, DISPLAY=7'b0111111, state_out=00 immediately.
